ofb_xor_stage: RTL

Keystream combiner between the raw-block RAM and the processed-block RAM in the GOST 28147-89 OFB datapath. It processes one 4096-byte sector per start pulse. For every 8 bytes it runs the gost core once on the current gamma register, feeds the result back as the next gamma (OFB), XORs that gamma with the raw bytes and writes the results to the processed RAM. The SD transfer logic starts it after a sector lands in the raw RAM and waits for `odone` before sending the processed RAM.

---
 rtl/ofb_xor_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ofb_xor_stage.sv
// ofb_xor_stage: GOST 28147-89 OFB keystream combiner for one sector.
// For each 8-byte group the gamma register is run through the external gost
// core. The result becomes the new gamma, and its bytes (MSB first) are XORed
// with the raw RAM stream into the processed RAM. Because XOR is its own
// inverse, the same pass both encrypts and decrypts.
module ofb_xor_stage #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              istart,
    input  logic              iload_iv,
    input  logic [63:0]       iiv,
    output logic              ogost_start,
    output logic [63:0]       ogost_block,
    input  logic [63:0]       igost_block,
    input  logic              igost_done,
    output logic [ADDR_W-1:0] oraddr,
    input  logic [DATA_W-1:0] irdata,
    output logic [ADDR_W-1:0] owaddr,
    output logic [DATA_W-1:0] owdata,
    output logic              owrite_en,
    output logic              obusy,
    output logic              odone
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_WAIT,
        S_RD,
        S_XFER
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [63:0]       gamma_q, gamma_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;   // byte whose read data is on irdata in XFER
    logic [2:0]        lane_q,  lane_d;
    logic              done_q,  done_d;
    logic [DATA_W-1:0] ks_byte;

    // State register; reset aborts any sector in flight.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q <= S_IDLE;
            gamma_q <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gamma_q <= gamma_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: one group = GEN, WAIT (gost latency), RD (prime read), 8x XFER.
    always_comb begin
        state_d = state_q;
        gamma_d = gamma_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // done_q still high means the odone cycle; a start there is dropped
                if (istart && !done_q) begin
                    if (iload_iv) gamma_d = iiv;
                    addr_d  = '0;
                    state_d = S_GEN;
                end
            end
            S_GEN: begin
                // gost start is issued here; a done in this same cycle is never taken
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (igost_done) begin
                    gamma_d = igost_block;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                lane_d  = '0;
                state_d = S_XFER;
            end
            S_XFER: begin
                addr_d = addr_q + ADDR_ONE;
                lane_d = lane_q + 3'd1;
                if (lane_q == 3'd7) begin
                    // address wrap after the last lane marks end of sector
                    if (addr_d == '0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GEN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Keystream byte for the current lane, MSB of gamma first.
    always_comb begin
        ks_byte = gamma_q[8*(7-int'(lane_q)) +: 8];
    end

    // Outputs decode straight from registered state, so reset clears them at once.
    always_comb begin
        ogost_start = (state_q == S_GEN);
        ogost_block = gamma_q;
        owrite_en   = (state_q == S_XFER);
        owaddr      = addr_q;
        owdata      = (state_q == S_XFER) ? (irdata ^ ks_byte) : '0;
        // RAM read is one cycle ahead: RD primes addr, XFER fetches the next byte
        oraddr      = (state_q == S_XFER) ? (addr_q + ADDR_ONE) : addr_q;
        odone       = done_q;
        // stay busy through the odone cycle so a start there is visibly refused
        obusy       = (state_q != S_IDLE) || done_q;
    end

endmodule
